// File: rtl/prog_mem_responder.sv
// Program-memory read responder: valid/ready request, programmable wait, held response,
// plus an independent single-cycle loader write port. Memory resets to a fixed boot image.
module prog_mem_responder #(
  parameter int ADDR_W   = 2,
  parameter int DATA_W   = 2,
  parameter int WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [7:0]        rd_count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYC);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [2:0]        cnt_r, cnt_nxt_s;
  logic [ADDR_W-1:0] addr_r, addr_nxt_s;
  logic [ADDR_W-1:0] cap_addr_s;
  logic [DATA_W-1:0] cap_data_s;
  logic              capture_s;
  logic              rd_inc_s;
  logic              req_ready_r;
  logic              rsp_valid_r;
  logic [DATA_W-1:0] rsp_data_r;
  logic [ADDR_W-1:0] rsp_addr_r;
  logic [7:0]        rd_count_r;
  logic [DATA_W-1:0] mem_r [DEPTH];

  // Boot image: only the low two bits of the first four words are non-zero.
  function automatic logic [DATA_W-1:0] reset_word(input int unsigned idx);
    logic [DATA_W-1:0] w;
    w = '0;
    case (idx)
      32'd1:   w[1:0] = 2'b01;
      32'd2:   w[1:0] = 2'b01;
      32'd3:   w[1:0] = 2'b10;
      default: w      = '0;
    endcase
    return w;
  endfunction

  // Write-first bypass so a loader write on the capture edge is returned.
  assign cap_data_s = (wr_en && (wr_addr == cap_addr_s)) ? wr_data : mem_r[cap_addr_s];

  // Next-state, wait counter and capture decode.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    addr_nxt_s  = addr_r;
    cap_addr_s  = addr_r;
    capture_s   = 1'b0;
    rd_inc_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          addr_nxt_s = req_addr;
          cnt_nxt_s  = WAIT_INIT;
          if (WAIT_INIT == 3'd0) begin
            state_nxt_s = RESP;
            capture_s   = 1'b1;
            cap_addr_s  = req_addr;
          end else begin
            state_nxt_s = WAIT;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        cnt_nxt_s = cnt_r - 3'd1;
        if (cnt_r <= 3'd1) begin
          state_nxt_s = RESP;
          capture_s   = 1'b1;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt_s = IDLE;
          rd_inc_s    = 1'b1;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 3'd0;
      end
    endcase
  end

  // FSM state, registered handshake outputs, response capture and read counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      cnt_r       <= 3'd0;
      addr_r      <= '0;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= '0;
      rsp_addr_r  <= '0;
      rd_count_r  <= 8'd0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      addr_r      <= addr_nxt_s;
      req_ready_r <= (state_nxt_s == IDLE);
      rsp_valid_r <= (state_nxt_s == RESP);
      if (capture_s) begin
        rsp_data_r <= cap_data_s;
        rsp_addr_r <= cap_addr_s;
      end
      if (rd_inc_s) begin
        rd_count_r <= rd_count_r + 8'd1;
      end
    end
  end

  // Program memory with loader write port; reset restores the boot image.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= reset_word(i);
      end
    end else if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_addr  = rsp_addr_r;
  assign rd_count  = rd_count_r;

endmodule

// File: tb/tb_prog_mem_responder.sv
// Bench for prog_mem_responder: three instances with WAIT_CYC = 0, 1, 2 (instance index equals
// its wait count), checked against an array memory model and transaction-level timing rules.
module tb_prog_mem_responder;

  logic       clk;
  logic       rst;
  logic       req_valid [3];
  logic [1:0] req_addr  [3];
  logic       req_ready [3];
  logic       rsp_valid [3];
  logic       rsp_ready [3];
  logic [1:0] rsp_data  [3];
  logic [1:0] rsp_addr  [3];
  logic       wr_en     [3];
  logic [1:0] wr_addr   [3];
  logic [1:0] wr_data   [3];
  logic [7:0] rd_count  [3];

  int checks;
  int errors;
  int cyc;
  int acc_cyc;
  logic [1:0] img [4];
  logic [1:0] mdl_mem [3][4];
  int mdl_cnt [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    prog_mem_responder #(.ADDR_W(2), .DATA_W(2), .WAIT_CYC(g)) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[g]), .req_addr(req_addr[g]), .req_ready(req_ready[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
      .rsp_data(rsp_data[g]), .rsp_addr(rsp_addr[g]),
      .wr_en(wr_en[g]), .wr_addr(wr_addr[g]), .wr_data(wr_data[g]),
      .rd_count(rd_count[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic mdl_reset();
    for (int u = 0; u < 3; u++) begin
      for (int a = 0; a < 4; a++) mdl_mem[u][a] = img[a];
      mdl_cnt[u] = 0;
    end
  endtask

  task automatic drive_wr(input int u, input bit en, input logic [1:0] a, input logic [1:0] d);
    wr_en[u] = en;
    wr_addr[u] = a;
    wr_data[u] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    mdl_reset();
  endtask

  task automatic write_word(input int u, input logic [1:0] a, input logic [1:0] d);
    drive_wr(u, 1'b1, a, d);
    @(posedge clk);
    @(negedge clk);
    drive_wr(u, 1'b0, 2'b00, 2'b00);
    mdl_mem[u][a] = d;
  endtask

  // One read transaction on instance u; optional loader write on edge wr_off after acceptance.
  task automatic do_read(input int u, input logic [1:0] addr, input int wr_off,
                         input logic [1:0] waddr, input logic [1:0] wdata, input int hold);
    logic [1:0] exp;
    int e;
    exp = mdl_mem[u][addr];
    if (wr_off >= 0 && wr_off <= u && waddr == addr) exp = wdata;
    checks++;
    if (req_ready[u] !== 1'b1) begin
      errors++;
      $display("FAIL ready_idle[%0d]: got %b want 1", u, req_ready[u]);
    end
    req_valid[u] = 1'b1;
    req_addr[u]  = addr;
    rsp_ready[u] = 1'b0;
    drive_wr(u, wr_off == 0, waddr, wdata);
    @(posedge clk);
    acc_cyc = cyc;
    @(negedge clk);
    req_valid[u] = 1'b0;
    e = 0;
    while (rsp_valid[u] !== 1'b1 && e < 20) begin
      drive_wr(u, wr_off == e + 1, waddr, wdata);
      @(posedge clk);
      @(negedge clk);
      e++;
    end
    checks++;
    if (rsp_valid[u] !== 1'b1 || e != u) begin
      errors++;
      $display("FAIL latency[%0d]: got %0d edges (valid=%b) want %0d", u, e, rsp_valid[u], u);
    end
    checks++;
    if (rsp_data[u] !== exp || rsp_addr[u] !== addr || req_ready[u] !== 1'b0) begin
      errors++;
      $display("FAIL response[%0d]: got data=%b addr=%b rdy=%b want data=%b addr=%b rdy=0",
               u, rsp_data[u], rsp_addr[u], req_ready[u], exp, addr);
    end
    for (int h = 0; h < hold; h++) begin
      drive_wr(u, wr_off == e + 1, waddr, wdata);
      @(posedge clk);
      @(negedge clk);
      e++;
      checks++;
      if (rsp_valid[u] !== 1'b1 || rsp_data[u] !== exp || req_ready[u] !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d]: got valid=%b data=%b rdy=%b want valid=1 data=%b rdy=0",
                 u, rsp_valid[u], rsp_data[u], req_ready[u], exp);
      end
    end
    rsp_ready[u] = 1'b1;
    drive_wr(u, wr_off == e + 1, waddr, wdata);
    @(posedge clk);
    @(negedge clk);
    rsp_ready[u] = 1'b0;
    drive_wr(u, 1'b0, 2'b00, 2'b00);
    if (wr_off >= 0) mdl_mem[u][waddr] = wdata;
    mdl_cnt[u]++;
    checks++;
    if (rsp_valid[u] !== 1'b0 || req_ready[u] !== 1'b1 || rd_count[u] !== 8'(mdl_cnt[u])) begin
      errors++;
      $display("FAIL consume[%0d]: got valid=%b rdy=%b cnt=%0d want valid=0 rdy=1 cnt=%0d",
               u, rsp_valid[u], req_ready[u], rd_count[u], mdl_cnt[u] % 256);
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int u = 0; u < 3; u++) begin
      checks++;
      if (req_ready[u] !== 1'b1 || rsp_valid[u] !== 1'b0 || rsp_data[u] !== 2'b00 ||
          rsp_addr[u] !== 2'b00 || rd_count[u] !== 8'd0) begin
        errors++;
        $display("FAIL reset[%0d]: got rdy=%b valid=%b data=%b addr=%b cnt=%0d want 1 0 00 00 0",
                 u, req_ready[u], rsp_valid[u], rsp_data[u], rsp_addr[u], rd_count[u]);
      end
    end
  endtask

  task automatic test_fetch();
    logic [1:0] boot [4];
    boot = '{2'b00, 2'b01, 2'b01, 2'b10};
    for (int a = 0; a < 4; a++) begin
      checks++;
      if (mdl_mem[1][a] !== boot[a]) begin
        errors++;
        $display("FAIL boot_image[%0d]: got %b want %b", a, mdl_mem[1][a], boot[a]);
      end
      do_read(1, 2'(a), -1, 2'b00, 2'b00, 0);
    end
    checks++;
    if (rd_count[1] !== 8'd4) begin
      errors++;
      $display("FAIL fetch_count: got %0d want 4", rd_count[1]);
    end
  endtask

  task automatic test_backpressure();
    do_read(1, 2'd3, 3, 2'd3, 2'b00, 5);
    checks++;
    if (mdl_mem[1][3] !== 2'b00) begin
      errors++;
      $display("FAIL bp_model: got %b want 00", mdl_mem[1][3]);
    end
  endtask

  task automatic test_collision();
    do_reset();
    do_read(2, 2'd2, 2, 2'd2, 2'b11, 0);
    checks++;
    if (rsp_data[2] !== 2'b11) begin
      errors++;
      $display("FAIL collision_capture: got %b want 11", rsp_data[2]);
    end
    do_reset();
    do_read(2, 2'd2, 3, 2'd2, 2'b11, 0);
    checks++;
    if (rsp_data[2] !== 2'b01) begin
      errors++;
      $display("FAIL collision_late: got %b want 01", rsp_data[2]);
    end
  endtask

  task automatic test_back_to_back();
    int prev;
    do_read(0, 2'($urandom_range(0, 3)), -1, 2'b00, 2'b00, 0);
    prev = acc_cyc;
    for (int k = 0; k < 8; k++) begin
      do_read(0, 2'($urandom_range(0, 3)), -1, 2'b00, 2'b00, 0);
      checks++;
      if (acc_cyc - prev != 2) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d cycles want 2", acc_cyc - prev);
      end
      prev = acc_cyc;
    end
  endtask

  task automatic test_midop_reset();
    do_reset();
    write_word(2, 2'd1, 2'b10);
    req_valid[2] = 1'b1;
    req_addr[2]  = 2'd1;
    @(posedge clk);
    @(negedge clk);
    req_valid[2] = 1'b0;
    rst = 1'b0;
    mdl_reset();
    for (int k = 0; k < 8; k++) begin
      if (k == 3) rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (rsp_valid[2] !== 1'b0 || rd_count[2] !== 8'd0) begin
        errors++;
        $display("FAIL midop_reset: got valid=%b cnt=%0d want 0 0", rsp_valid[2], rd_count[2]);
      end
    end
    do_read(2, 2'd1, -1, 2'b00, 2'b00, 0);
    checks++;
    if (rsp_data[2] !== 2'b01) begin
      errors++;
      $display("FAIL midop_restore: got %b want 01", rsp_data[2]);
    end
  endtask

  task automatic test_random();
    for (int u = 0; u < 3; u++) begin
      for (int k = 0; k < 30; k++) begin
        logic [1:0] a, wa, wd;
        int hold, off;
        a = 2'($urandom_range(0, 3));
        wa = ($urandom_range(0, 1) == 0) ? a : 2'($urandom_range(0, 3));
        wd = 2'($urandom_range(0, 3));
        hold = $urandom_range(0, 3);
        off = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, u + hold + 1));
        if ($urandom_range(0, 3) == 0) write_word(u, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        do_read(u, a, off, wa, wd, hold);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 256; k++) do_read(0, 2'(k), -1, 2'b00, 2'b00, 0);
    checks++;
    if (rd_count[0] !== 8'd0) begin
      errors++;
      $display("FAIL wrap: got %0d want 0", rd_count[0]);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    img = '{2'b00, 2'b01, 2'b01, 2'b10};
    rst = 1'b1;
    for (int u = 0; u < 3; u++) begin
      req_valid[u] = 1'b0;
      req_addr[u]  = 2'b00;
      rsp_ready[u] = 1'b0;
      drive_wr(u, 1'b0, 2'b00, 2'b00);
    end
    mdl_reset();
    test_reset();
    test_fetch();
    test_backpressure();
    test_collision();
    test_back_to_back();
    test_midop_reset();
    test_random();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
